// File: rtl/axis_packet_add_pkg.sv
// Shared types and helpers for the AXIS packet accumulator.
// The saturating adder is only referenced when AXIS_PACKET_ADD_SATURATE_EN is defined.
package axis_packet_add_pkg;

    localparam int DW_DEF = 8;
    localparam int DD_DEF = 64;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DW_DEF-1:0] k;
        logic [DW_DEF-1:0] len;
    } cfg_t;

    function automatic logic [DW_DEF-1:0] sat_add(input logic [DW_DEF-1:0] a,
                                                   input logic [DW_DEF-1:0] b);
        logic [DW_DEF:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW_DEF] ? {DW_DEF{1'b1}} : s[DW_DEF-1:0];
    endfunction

endpackage

// File: rtl/axis_packet_add_buf.sv
// DD x DW accumulation buffer: one write port, two combinational read ports
// (port a feeds read-modify-write, port b feeds the result stream).
module axis_packet_add_buf
    import axis_packet_add_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int DD = DD_DEF,
    localparam int AW = $clog2(DD)
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          we,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    // No reset: packet 0 of every group overwrites the words it uses.
    logic [DW-1:0] mem_q [DD];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/axis_packet_add.sv
// AXI-Stream packet accumulator: sums k packets element-wise, then streams one result packet.
// Define AXIS_PACKET_ADD_SATURATE_EN for clamping adds instead of wrap-around.
module axis_packet_add
    import axis_packet_add_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int DD = DD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    input  logic [2*DW-1:0] config_packet
);

    localparam int AW = $clog2(DD);
    localparam int LW = $clog2(DD + 1);
    localparam logic [LW-1:0] DD_L = LW'(DD);
    localparam logic [DW:0]   DD_X = (DW+1)'(DD);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] oidx_q, oidx_d;
    logic [DW-1:0] pkt_q, pkt_d;
    logic [LW-1:0] out_len_q, out_len_d;
    logic [DW-1:0] k_q, k_d;
    logic [LW-1:0] len_q, len_d;

    cfg_t          cfg_in;
    logic [DW-1:0] k_in, k_cur;
    logic [LW-1:0] len_in, len_cur;
    logic          first_beat, fire, pkt_end, in_range, last_out;
    logic          we;
    logic [DW-1:0] wdata, rd_a, rd_b, sum;

    assign cfg_in = config_packet;
    assign k_in   = (cfg_in.k == '0) ? DW'(1) : cfg_in.k;
    assign len_in = (cfg_in.len == '0 || {1'b0, cfg_in.len} > DD_X) ? DD_L : cfg_in.len[LW-1:0];

    // The first beat of a group uses the live config; later beats use the captured copy.
    assign first_beat = (state_q == ACCUM) && (pkt_q == '0) && (idx_q == '0);
    assign k_cur      = first_beat ? k_in : k_q;
    assign len_cur    = first_beat ? len_in : len_q;

    assign fire     = (state_q == ACCUM) && s_tvalid;
    assign pkt_end  = s_tlast || (LW'(idx_q) == len_cur - LW'(1));
    assign in_range = (pkt_q == '0) || (LW'(idx_q) < out_len_q);
    assign last_out = (LW'(oidx_q) == out_len_q - LW'(1));

`ifdef AXIS_PACKET_ADD_SATURATE_EN
    assign sum = sat_add(rd_a, s_tdata);
`else
    assign sum = rd_a + s_tdata;
`endif

    assign we    = fire && in_range;
    assign wdata = (pkt_q == '0) ? s_tdata : sum;

    axis_packet_add_buf #(.DW(DW), .DD(DD)) u_buf (
        .clk     (clk),
        .waddr   (idx_q),
        .wdata   (wdata),
        .we      (we),
        .raddr_a (idx_q),
        .rdata_a (rd_a),
        .raddr_b (oidx_q),
        .rdata_b (rd_b)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        oidx_d    = oidx_q;
        pkt_d     = pkt_q;
        out_len_d = out_len_q;
        k_d       = k_q;
        len_d     = len_q;
        case (state_q)
            ACCUM: begin
                if (fire) begin
                    if (first_beat) begin
                        k_d   = k_in;
                        len_d = len_in;
                    end
                    if (pkt_end) begin
                        idx_d = '0;
                        if (pkt_q == '0) begin
                            out_len_d = LW'(idx_q) + LW'(1);
                        end
                        if (pkt_q == k_cur - DW'(1)) begin
                            state_d = OUTPUT;
                            pkt_d   = '0;
                            oidx_d  = '0;
                        end else begin
                            pkt_d = pkt_q + DW'(1);
                        end
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            OUTPUT: begin
                if (m_tready) begin
                    if (last_out) begin
                        state_d = ACCUM;
                        oidx_d  = '0;
                    end else begin
                        oidx_d = oidx_q + AW'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            idx_q     <= '0;
            oidx_q    <= '0;
            pkt_q     <= '0;
            out_len_q <= '0;
            k_q       <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            oidx_q    <= oidx_d;
            pkt_q     <= pkt_d;
            out_len_q <= out_len_d;
            k_q       <= k_d;
            len_q     <= len_d;
        end
    end

    assign s_tready = !rst && (state_q == ACCUM);
    assign m_tvalid = !rst && (state_q == OUTPUT);
    assign m_tlast  = m_tvalid && last_out;
    assign m_tdata  = m_tvalid ? rd_b : '0;

endmodule

// File: tb/tb_axis_packet_add.sv
// Directed, self-checking bench for axis_packet_add with a result scoreboard.
// Expected sums follow AXIS_PACKET_ADD_SATURATE_EN when it is defined.
module tb_axis_packet_add;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [2*DW-1:0] config_packet = '0;

    int tests = 0;
    int fails = 0;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] pkt_d [64];
    logic [DW-1:0] acc [64];
    int            olen = 0;

    axis_packet_add dut (
        .clk           (clk),
        .rst           (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .config_packet (config_packet)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef AXIS_PACKET_ADD_SATURATE_EN
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
`else
        return s[DW-1:0];
`endif
    endfunction

    task automatic model_pkt(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            if (p == 0) acc[i] = pkt_d[i];
            else if (i < olen) acc[i] = model_add(acc[i], pkt_d[i]);
        end
        if (p == 0) olen = n;
    endtask

    task automatic push_result();
        for (int i = 0; i < olen; i++) begin
            exp_q.push_back({(i == olen - 1) ? 1'b1 : 1'b0, acc[i]});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_s_tready", s_tready, 0);
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_m_tlast", m_tlast, 0);
            check("rst_m_tdata", m_tdata, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_tready", s_tready, 1);
        check("post_rst_m_tvalid", m_tvalid, 0);
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int guard = 0;
        s_tdata = d;
        s_tvalid = 1'b1;
        s_tlast = last;
        check("in_m_tvalid", m_tvalid, 0);
        while (s_tready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", (guard < 100) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    task automatic send_pkt(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            send_beat(pkt_d[i], (use_last && i == n - 1) ? 1'b1 : 1'b0);
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    // Drains every queued result; with toggle, m_tready alternates so beats must hold.
    task automatic recv(input bit toggle);
        int cyc = 0;
        bit rdy = 1'b0;
        bit have_prev = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        logic [DW:0] e;
        while (exp_q.size() > 0 && cyc < 2000) begin
            m_tready = toggle ? rdy : 1'b1;
            if (m_tvalid) begin
                check("out_s_tready", s_tready, 0);
                if (have_prev) begin
                    check("hold_tdata", m_tdata, pd);
                    check("hold_tlast", m_tlast, pl);
                end
                if (m_tready) begin
                    e = exp_q.pop_front();
                    check("out_tdata", m_tdata, e[DW-1:0]);
                    check("out_tlast", m_tlast, e[DW]);
                    have_prev = 1'b0;
                end else begin
                    pd = m_tdata;
                    pl = m_tlast;
                    have_prev = 1'b1;
                end
            end
            rdy = ~rdy;
            @(negedge clk);
            cyc++;
        end
        check("recv_budget", (cyc < 2000) ? 1 : 0, 1);
        exp_q.delete();
        m_tready = 1'b1;
        check("after_out_m_tvalid", m_tvalid, 0);
        check("after_out_s_tready", s_tready, 1);
    endtask

    initial begin
        // 1: reset
        do_reset();

        // 2: k=2 len=64, A=i then B=2i with tlast on beat 63
        config_packet = {8'd2, 8'd64};
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'(i);
        model_pkt(64, 0);
        send_pkt(64, 1'b0);
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'(2 * i);
        model_pkt(64, 1);
        send_pkt(64, 1'b1);
        check("s2_latency_m_tvalid", m_tvalid, 1);
        check("s2_first_data", m_tdata, 0);
        push_result();
        recv(1'b0);

        // 3: a second random group, then one leftover beat that must stay pending
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'($urandom_range(0, 255));
        model_pkt(64, 0);
        send_pkt(64, 1'b0);
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'($urandom_range(0, 255));
        model_pkt(64, 1);
        send_pkt(64, 1'b0);
        check("s3_latency_m_tvalid", m_tvalid, 1);
        push_result();
        recv(1'b0);
        send_beat(8'd77, 1'b0);
        s_tvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("s3_leftover_m_tvalid", m_tvalid, 0);
            check("s3_leftover_s_tready", s_tready, 1);
        end
        do_reset();

        // 4: scenario 2 with toggling m_tready; config change mid-group is ignored
        config_packet = {8'd2, 8'd64};
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'(i);
        model_pkt(64, 0);
        send_pkt(64, 1'b0);
        config_packet = {8'd1, 8'd4};
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'(2 * i);
        model_pkt(64, 1);
        send_pkt(64, 1'b1);
        check("s4_latency_m_tvalid", m_tvalid, 1);
        push_result();
        recv(1'b1);

        // 5: overflow case, k=2 len=4
        config_packet = {8'd2, 8'd4};
        pkt_d[0] = 8'd200; pkt_d[1] = 8'd1; pkt_d[2] = 8'd2; pkt_d[3] = 8'd3;
        model_pkt(4, 0);
        send_pkt(4, 1'b0);
        pkt_d[0] = 8'd100;
        model_pkt(4, 1);
        send_pkt(4, 1'b0);
`ifdef AXIS_PACKET_ADD_SATURATE_EN
        check("s5_beat0_const", m_tdata, 255);
`else
        check("s5_beat0_const", m_tdata, 44);
`endif
        push_result();
        recv(1'b0);

        // 6: k=1 len=8, tlast on beat 5
        config_packet = {8'd1, 8'd8};
        for (int i = 0; i < 6; i++) pkt_d[i] = 8'(10 + i);
        model_pkt(6, 0);
        send_pkt(6, 1'b1);
        push_result();
        recv(1'b0);

        // 7: k=0 -> 1 and len>DD -> DD; then len=0 -> DD
        config_packet = {8'd0, 8'd200};
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'($urandom_range(0, 255));
        model_pkt(64, 0);
        send_pkt(64, 1'b0);
        check("s7_kzero_m_tvalid", m_tvalid, 1);
        push_result();
        recv(1'b0);
        config_packet = {8'd1, 8'd0};
        for (int i = 0; i < 64; i++) pkt_d[i] = 8'($urandom_range(0, 255));
        model_pkt(64, 0);
        send_pkt(64, 1'b0);
        check("s7_lenzero_m_tvalid", m_tvalid, 1);
        push_result();
        recv(1'b0);

        // 8: later packet longer than packet 0; excess beats discarded
        config_packet = {8'd2, 8'd8};
        for (int i = 0; i < 3; i++) pkt_d[i] = 8'($urandom_range(0, 255));
        model_pkt(3, 0);
        send_pkt(3, 1'b1);
        for (int i = 0; i < 6; i++) pkt_d[i] = 8'($urandom_range(0, 255));
        model_pkt(6, 1);
        send_pkt(6, 1'b1);
        push_result();
        recv(1'b1);

        // 9: reset while a result is pending discards it
        config_packet = {8'd1, 8'd2};
        pkt_d[0] = 8'd5; pkt_d[1] = 8'd6;
        send_pkt(2, 1'b0);
        check("s9_pending_m_tvalid", m_tvalid, 1);
        do_reset();
        repeat (2) begin
            @(negedge clk);
            check("s9_idle_m_tvalid", m_tvalid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
